// File: rtl/wt_frame_fifo_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wt_frame_fifo_writer_pkg
// Brief    : Shared widths, turbine count and FSM encoding for the frame writer.
// Revision : 1.0 - initial release
// ============================================================================
package wt_frame_fifo_writer_pkg;

    localparam int c_DATA_W          = 64;
    localparam int c_N_WIND_TURBINE  = 8;
    localparam int c_DEPTH           = 16;
    localparam int c_AW              = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wt_frame_fifo_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : wt_frame_fifo_writer_if
// Brief    : Upstream handshake, FIFO write side and status of the frame writer.
// Revision : 1.0 - initial release
// ============================================================================
interface wt_frame_fifo_writer_if
    import wt_frame_fifo_writer_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
);
    logic              frame_start;
    logic              din_valid;
    logic [DATA_W-1:0] din;
    logic              din_ready;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              frame_done;
    logic              busy;
    logic              err;

    modport slave (
        input  frame_start, din_valid, din,
        output din_ready, wr_en, wr_data, frame_done, busy, err
    );

    modport master (
        output frame_start, din_valid, din,
        input  din_ready, wr_en, wr_data, frame_done, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/wt_frame_fifo_writer_buf.sv
`default_nettype none
// ============================================================================
// Module   : wt_frame_buf
// Brief    : Simple dual-port frame RAM, synchronous write and registered read.
// Revision : 1.0 - initial release
// ============================================================================
module wt_frame_buf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  wire logic              clk,
    input  wire logic              we_i,
    input  wire logic [AW-1:0]     waddr_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    input  wire logic              re_i,
    input  wire logic [AW-1:0]     raddr_i,
    output logic      [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/wt_frame_fifo_writer.sv
`default_nettype none
// ============================================================================
// Module   : wt_frame_fifo_writer
// Brief    : Collects one word per turbine, then replays the frame as a
//            contiguous FIFO write burst followed by a frame_done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module wt_frame_fifo_writer
    import wt_frame_fifo_writer_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int N_WT   = c_N_WIND_TURBINE,
    parameter int DEPTH  = c_DEPTH,
    parameter int AW     = c_AW
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              rst_user,
    wt_frame_fifo_writer_if.slave  bus
);

    // One extra bit so a counter can hold N_WT == DEPTH.
    localparam int           c_CW   = AW + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(N_WT - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    state_t            state_q, state_d;
    logic [c_CW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [c_CW-1:0]   rd_cnt_q, rd_cnt_d;
    logic              din_ready_q, din_ready_d;
    logic              rd_vld_q, rd_vld_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              w_accept;
    logic              w_rd_issue;
    logic [DATA_W-1:0] w_buf_rdata;

    assign w_accept   = (state_q == ST_COLLECT) && din_ready_q && bus.din_valid && !rst_user;
    assign w_rd_issue = (state_q == ST_DRAIN) && !rst_user;

    wt_frame_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_buf (
        .clk     (clk),
        .we_i    (w_accept),
        .waddr_i (wr_cnt_q[AW-1:0]),
        .wdata_i (bus.din),
        .re_i    (w_rd_issue),
        .raddr_i (rd_cnt_q[AW-1:0]),
        .rdata_o (w_buf_rdata)
    );

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        err_d        = err_q;
        frame_done_d = 1'b0;

        if (rst_user) begin
            state_d  = ST_IDLE;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
        end else begin
            if (bus.frame_start && (state_q != ST_IDLE)) begin
                err_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.frame_start) begin
                        state_d  = ST_COLLECT;
                        wr_cnt_d = '0;
                    end
                end
                ST_COLLECT: begin
                    if (w_accept) begin
                        wr_cnt_d = wr_cnt_q + c_ONE;
                        if (wr_cnt_q == c_LAST) begin
                            state_d  = ST_DRAIN;
                            rd_cnt_d = '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    rd_cnt_d = rd_cnt_q + c_ONE;
                    if (rd_cnt_q == c_LAST) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Hold here until the read pipeline has emptied so that
                    // frame_done lands right after the last FIFO write.
                    if (frame_done_q) begin
                        state_d = ST_IDLE;
                    end else if (!rd_vld_q) begin
                        frame_done_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        din_ready_d = (state_d == ST_COLLECT);
        busy_d      = (state_d != ST_IDLE);
        rd_vld_d    = w_rd_issue;
        wr_en_d     = rd_vld_q && !rst_user;
        wr_data_d   = wr_en_d ? w_buf_rdata : wr_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            din_ready_q  <= 1'b0;
            rd_vld_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            din_ready_q  <= din_ready_d;
            rd_vld_q     <= rd_vld_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign bus.din_ready  = din_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wt_frame_fifo_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wt_frame_fifo_writer
// Brief    : Directed bench with a timeline model of the frame writer outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wt_frame_fifo_writer;
    import wt_frame_fifo_writer_pkg::*;

    localparam int DATA_W = 64;
    localparam int N_WT   = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int INF    = 1 << 30;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic rst_user = 1'b0;

    wt_frame_fifo_writer_if #(.DATA_W(DATA_W)) bus ();

    wt_frame_fifo_writer #(
        .DATA_W (DATA_W),
        .N_WT   (N_WT),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rst_user (rst_user),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_k  = 0;

    always @(posedge clk) edge_k <= edge_k + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_k);
        end
    endtask

    // Timeline model: each output is described by the edge numbers at which
    // it starts/stops, derived from frame starts, accepts and resets.
    bit          m_on      = 1'b0;
    int          busy_from = INF, busy_end = INF;
    int          rdy_from  = INF, rdy_end  = INF;
    int          err_from  = INF;
    int          bs        = -1000;
    int          cut       = INF;
    int          zero_at   = -1;
    int          m_cnt     = 0;
    logic [63:0] m_frame [N_WT];
    logic [63:0] m_burst [N_WT];
    logic [63:0] m_hold    = '0;

    logic [63:0] obs_q [$];
    int first_wr = -1, last_wr = -1, last_acc = -1, done_obs = -1, done_cnt = 0, rdy_off = -1;
    bit prev_rdy = 1'b0;
    int clr_gen  = 0;
    int clr_seen = 0;

    always @(negedge clk) begin
        int k;
        bit e_en, e_done, e_busy, e_rdy, e_err;
        k      = edge_k;
        e_en   = (k >= bs) && (k < bs + N_WT) && (k < cut);
        e_done = (k == bs + N_WT) && (k < cut);
        e_busy = (k >= busy_from) && (k < busy_end);
        e_rdy  = (k >= rdy_from) && (k < rdy_end);
        e_err  = (k >= err_from);
        if (k == zero_at) m_hold = '0;
        if (e_en) m_hold = m_burst[k - bs];

        if (m_on) begin
            chk("cyc_wr_en",      bus.wr_en,      e_en);
            chk("cyc_wr_data",    bus.wr_data,    m_hold);
            chk("cyc_frame_done", bus.frame_done, e_done);
            chk("cyc_busy",       bus.busy,       e_busy);
            chk("cyc_din_ready",  bus.din_ready,  e_rdy);
            chk("cyc_err",        bus.err,        e_err);
        end

        if (clr_seen != clr_gen) begin
            clr_seen = clr_gen;
            obs_q.delete();
            first_wr = -1; last_wr = -1; last_acc = -1;
            done_obs = -1; done_cnt = 0; rdy_off = -1;
        end
        if (bus.wr_en === 1'b1) begin
            obs_q.push_back(bus.wr_data);
            if (first_wr < 0) first_wr = k;
            last_wr = k;
        end
        if (bus.frame_done === 1'b1) begin
            done_cnt++;
            done_obs = k;
        end
        if (prev_rdy && (bus.din_ready === 1'b0)) rdy_off = k;
        prev_rdy = (bus.din_ready === 1'b1);
        if ((bus.din_valid === 1'b1) && (bus.din_ready === 1'b1)) last_acc = k + 1;

        if (rst) begin
            m_on     = 1'b1;
            cut      = k + 1;
            busy_end = (busy_end > k + 1) ? k + 1 : busy_end;
            rdy_end  = (rdy_end > k + 1) ? k + 1 : rdy_end;
            err_from = INF;
            zero_at  = k + 1;
            m_cnt    = 0;
        end else if (rst_user) begin
            cut      = k + 1;
            busy_end = (busy_end > k + 1) ? k + 1 : busy_end;
            rdy_end  = (rdy_end > k + 1) ? k + 1 : rdy_end;
            m_cnt    = 0;
        end else if (m_on) begin
            if (bus.frame_start) begin
                if (e_busy) begin
                    if (err_from > k + 1) err_from = k + 1;
                end else begin
                    busy_from = k + 1; busy_end = INF;
                    rdy_from  = k + 1; rdy_end  = INF;
                    m_cnt     = 0;
                end
            end
            if (e_rdy && bus.din_valid) begin
                m_frame[m_cnt] = bus.din;
                m_cnt++;
                if (m_cnt == N_WT) begin
                    m_burst  = m_frame;
                    rdy_end  = k + 1;
                    bs       = k + 3;
                    cut      = INF;
                    busy_end = bs + N_WT + 1;
                    m_cnt    = 0;
                end
            end
        end
    end

    int drv_idx;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        clr_gen++;
    endtask

    task automatic start_frame();
        bus.frame_start = 1'b1;
        tick(1);
        bus.frame_start = 1'b0;
    endtask

    task automatic send(input logic [63:0] base, input int nacc, input bit gapped, input int hold);
        int p = 0;
        int budget = 0;
        bit acc;
        drv_idx = 0;
        while ((drv_idx < nacc) && (budget < 200)) begin
            bus.din       = base + 64'(drv_idx);
            bus.din_valid = gapped ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
            p++;
            acc = bus.din_valid && bus.din_ready;
            tick(1);
            if (acc) drv_idx++;
            budget++;
        end
        chk("send_accepts", drv_idx, nacc);
        for (int i = 0; i < hold; i++) begin
            bus.din       = base + 64'(drv_idx);
            bus.din_valid = 1'b1;
            acc = bus.din_ready;
            tick(1);
            if (acc) drv_idx++;
        end
        bus.din_valid = 1'b0;
    endtask

    task automatic wait_done();
        int b = 0;
        while ((bus.frame_done !== 1'b1) && (b < 100)) begin
            tick(1);
            b++;
        end
        chk("done_seen", bus.frame_done, 1'b1);
    endtask

    task automatic check_burst(input string tag, input logic [63:0] base);
        chk({tag, "_len"}, obs_q.size(), N_WT);
        for (int i = 0; i < obs_q.size() && i < N_WT; i++)
            chk({tag, "_word"}, obs_q[i], base + 64'(i));
        chk({tag, "_latency"}, first_wr - last_acc, 2);
        chk({tag, "_contig"}, last_wr - first_wr, N_WT - 1);
        chk({tag, "_done_after"}, done_obs - last_wr, 1);
        chk({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        int seen;
        int b;
        bus.frame_start = 1'b0;
        bus.din_valid   = 1'b0;
        bus.din         = '0;

        rst = 1'b1;
        tick(3);
        chk("rst_wr_en",      bus.wr_en,      1'b0);
        chk("rst_wr_data",    bus.wr_data,    64'h0);
        chk("rst_frame_done", bus.frame_done, 1'b0);
        chk("rst_busy",       bus.busy,       1'b0);
        chk("rst_err",        bus.err,        1'b0);
        chk("rst_din_ready",  bus.din_ready,  1'b0);
        rst = 1'b0;
        tick(2);

        // Basic frame, back-to-back words
        clear_obs();
        start_frame();
        send(64'h10, 8, 1'b0, 0);
        wait_done();
        tick(1);
        chk("basic_busy_after", bus.busy, 1'b0);
        tick(1);
        check_burst("basic", 64'h10);

        // Gapped input
        clear_obs();
        start_frame();
        send(64'h10, 8, 1'b1, 0);
        wait_done();
        tick(2);
        check_burst("gapped", 64'h10);

        // Backpressure: valid held through and past the frame
        clear_obs();
        start_frame();
        send(64'h20, 8, 1'b0, 14);
        tick(1);
        chk("bp_pending_word", 64'h20 + 64'(drv_idx), 64'h28);
        chk("bp_rdy_off", rdy_off, last_acc);
        chk("bp_err", bus.err, 1'b0);
        check_burst("bp", 64'h20);

        // Overlap: frame_start during DRAIN and coincident with frame_done
        clear_obs();
        start_frame();
        send(64'h50, 8, 1'b0, 0);
        tick(2);
        start_frame();
        chk("ov_err_drain", bus.err, 1'b1);
        wait_done();
        bus.frame_start = 1'b1;
        tick(1);
        bus.frame_start = 1'b0;
        chk("ov_busy_ignored", bus.busy, 1'b0);
        tick(1);
        check_burst("overlap", 64'h50);
        tick(3);
        chk("ov_idle", bus.busy, 1'b0);
        rst_user = 1'b1;
        tick(1);
        rst_user = 1'b0;
        chk("ov_err_after_rst_user", bus.err, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("ov_err_after_rst", bus.err, 1'b0);
        tick(2);

        // Abort after the third FIFO write
        clear_obs();
        start_frame();
        send(64'h30, 8, 1'b0, 0);
        seen = 0;
        b = 0;
        while (b < 50) begin
            if (bus.wr_en === 1'b1) seen++;
            if (seen == 3) break;
            tick(1);
            b++;
        end
        chk("ab_third_write", seen, 3);
        rst_user = 1'b1;
        tick(1);
        rst_user = 1'b0;
        chk("ab_wr_en", bus.wr_en, 1'b0);
        chk("ab_busy", bus.busy, 1'b0);
        chk("ab_wr_data_kept", bus.wr_data, 64'h32);
        tick(15);
        chk("ab_no_done", done_cnt, 0);
        chk("ab_partial_len", obs_q.size(), 3);

        clear_obs();
        start_frame();
        send(64'h40, 8, 1'b0, 0);
        wait_done();
        tick(2);
        check_burst("after_abort", 64'h40);

        // Reset mid-collect
        clear_obs();
        start_frame();
        send(64'h60, 3, 1'b0, 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rc_wr_en",      bus.wr_en,      1'b0);
        chk("rc_wr_data",    bus.wr_data,    64'h0);
        chk("rc_frame_done", bus.frame_done, 1'b0);
        chk("rc_busy",       bus.busy,       1'b0);
        chk("rc_err",        bus.err,        1'b0);
        chk("rc_din_ready",  bus.din_ready,  1'b0);
        tick(20);
        chk("rc_no_write", obs_q.size(), 0);
        chk("rc_no_done", done_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
